// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
//   Unified reservation station between dispatch and the ALU, load/store and
//   branch pipes. Holds up to RS_DEPTH renamed micro-ops, tracks operand
//   readiness from two writeback wakeup ports, and each cycle offers the
//   oldest eligible entry of each functional-unit class to its pipe.
//
//   Optional feature macro: ISSUE_WAKEUP_BYPASS_EN
//     defined   : same-cycle wakeups count toward eligibility (0-cycle select)
//     undefined : wakeups only update ready bits at the clock edge
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               squash every entry at the next edge
//   disp_*              one micro-op per cycle from dispatch (valid/ready)
//   wb0_*, wb1_*        wakeup broadcasts (valid + physical tag)
//   alu_*, ls_*, br_*   per-class issue ports (valid/ready, rob, src tags)
//   occupancy           number of valid entries
module rs_issue_scheduler #(
  parameter int ROB_WIDTH = 5,
  parameter int PHY_WIDTH = 6,
  parameter int RS_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [ROB_WIDTH-1:0]         disp_rob,
  input  logic [1:0]                   disp_fu,
  input  logic [PHY_WIDTH-1:0]         disp_src1,
  input  logic [PHY_WIDTH-1:0]         disp_src2,
  input  logic                         disp_rdy1,
  input  logic                         disp_rdy2,
  input  logic                         wb0_valid,
  input  logic [PHY_WIDTH-1:0]         wb0_tag,
  input  logic                         wb1_valid,
  input  logic [PHY_WIDTH-1:0]         wb1_tag,
  output logic                         alu_valid,
  input  logic                         alu_ready,
  output logic [ROB_WIDTH-1:0]         alu_rob,
  output logic [PHY_WIDTH-1:0]         alu_src1,
  output logic [PHY_WIDTH-1:0]         alu_src2,
  output logic                         ls_valid,
  input  logic                         ls_ready,
  output logic [ROB_WIDTH-1:0]         ls_rob,
  output logic [PHY_WIDTH-1:0]         ls_src1,
  output logic [PHY_WIDTH-1:0]         ls_src2,
  output logic                         br_valid,
  input  logic                         br_ready,
  output logic [ROB_WIDTH-1:0]         br_rob,
  output logic [PHY_WIDTH-1:0]         br_src1,
  output logic [PHY_WIDTH-1:0]         br_src2,
  output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(RS_DEPTH + 1);
  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Entry state
  logic [RS_DEPTH-1:0]  valid_q, valid_d;
  logic [RS_DEPTH-1:0]  rdy1_q, rdy1_d;
  logic [RS_DEPTH-1:0]  rdy2_q, rdy2_d;
  logic [ROB_WIDTH-1:0] rob_q  [RS_DEPTH];
  logic [1:0]           fu_q   [RS_DEPTH];
  logic [PHY_WIDTH-1:0] src1_q [RS_DEPTH];
  logic [PHY_WIDTH-1:0] src2_q [RS_DEPTH];
  // Age matrix: older_q[i][j] = 1 when entry i was dispatched before entry j.
  // Bits involving invalid entries are stale but are always masked by
  // eligibility, and are rewritten when the slot is reused.
  logic [RS_DEPTH-1:0]  older_q [RS_DEPTH];
  logic [RS_DEPTH-1:0]  older_d [RS_DEPTH];

  logic [RS_DEPTH-1:0]  wake1, wake2, op1_ok, op2_ok, elig;
  logic                 disp_wake1, disp_wake2, disp_accept;
  logic [IDX_W-1:0]     free_idx;
  logic [OCC_W-1:0]     occ;

  logic [2:0]           cls_valid, cls_ready, cls_fire;
  logic [IDX_W-1:0]     cls_idx  [3];
  logic [ROB_WIDTH-1:0] cls_rob  [3];
  logic [PHY_WIDTH-1:0] cls_src1 [3];
  logic [PHY_WIDTH-1:0] cls_src2 [3];

  // Wakeup tag matches for resident entries and for the incoming micro-op
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake1[i] = (wb0_valid && (wb0_tag == src1_q[i])) || (wb1_valid && (wb1_tag == src1_q[i]));
      wake2[i] = (wb0_valid && (wb0_tag == src2_q[i])) || (wb1_valid && (wb1_tag == src2_q[i]));
    end
  end

  assign disp_wake1 = (wb0_valid && (wb0_tag == disp_src1)) || (wb1_valid && (wb1_tag == disp_src1));
  assign disp_wake2 = (wb0_valid && (wb0_tag == disp_src2)) || (wb1_valid && (wb1_tag == disp_src2));

`ifdef ISSUE_WAKEUP_BYPASS_EN
  assign op1_ok = rdy1_q | wake1;
  assign op2_ok = rdy2_q | wake2;
`else
  assign op1_ok = rdy1_q;
  assign op2_ok = rdy2_q;
`endif

  assign elig = valid_q & op1_ok & op2_ok;

  always_comb begin
    occ = '0;
    for (int i = 0; i < RS_DEPTH; i++) occ = occ + OCC_W'(valid_q[i]);
  end
  assign occupancy = occ;

  // Lowest-numbered free slot; only used when the station is not full
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // Slots freed by issue this cycle are deliberately not counted as free
  assign disp_ready  = (occ < OCC_W'(RS_DEPTH)) && !flush && !rst;
  assign disp_accept = disp_valid && disp_ready;

  assign cls_ready = {br_ready, ls_ready, alu_ready};
  assign cls_fire  = cls_valid & cls_ready;

  // Per-class oldest-eligible select: the winner is the candidate that no
  // other candidate of the same class is older than.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sel
    logic [RS_DEPTH-1:0] cand;
    logic                found;
    logic [IDX_W-1:0]    pick;

    always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) cand[i] = elig[i] && (fu_q[i] == 2'(gi));
    end

    always_comb begin
      logic blocked;
      blocked = 1'b0;
      found   = 1'b0;
      pick    = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        blocked = 1'b0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (cand[j] && older_q[j][i]) blocked = 1'b1;
        end
        if (cand[i] && !blocked && !found) begin
          found = 1'b1;
          pick  = IDX_W'(i);
        end
      end
    end

    assign cls_valid[gi] = found && !flush && !rst;
    assign cls_idx[gi]   = pick;
    assign cls_rob[gi]   = cls_valid[gi] ? rob_q[pick]  : '0;
    assign cls_src1[gi]  = cls_valid[gi] ? src1_q[pick] : '0;
    assign cls_src2[gi]  = cls_valid[gi] ? src2_q[pick] : '0;
  end

  assign alu_valid = cls_valid[0];
  assign alu_rob   = cls_rob[0];
  assign alu_src1  = cls_src1[0];
  assign alu_src2  = cls_src2[0];
  assign ls_valid  = cls_valid[1];
  assign ls_rob    = cls_rob[1];
  assign ls_src1   = cls_src1[1];
  assign ls_src2   = cls_src2[1];
  assign br_valid  = cls_valid[2];
  assign br_rob    = cls_rob[2];
  assign br_src1   = cls_src1[2];
  assign br_src2   = cls_src2[2];

  // Next-state for entry bookkeeping
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q | wake1;
    rdy2_d  = rdy2_q | wake2;
    for (int i = 0; i < RS_DEPTH; i++) older_d[i] = older_q[i];

    for (int c = 0; c < 3; c++) begin
      if (cls_fire[c]) valid_d[cls_idx[c]] = 1'b0;
    end

    if (disp_accept) begin
      valid_d[free_idx] = 1'b1;
      rdy1_d[free_idx]  = disp_rdy1 | disp_wake1;
      rdy2_d[free_idx]  = disp_rdy2 | disp_wake2;
      // New entry is younger than every resident entry
      for (int j = 0; j < RS_DEPTH; j++) older_d[j][free_idx] = valid_q[j];
      older_d[free_idx] = '0;
    end

    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  // Payload needs no reset: it is only observed while the entry is valid
  always_ff @(posedge clk) begin
    if (disp_accept) begin
      rob_q[free_idx]  <= disp_rob;
      fu_q[free_idx]   <= disp_fu;
      src1_q[free_idx] <= disp_src1;
      src2_q[free_idx] <= disp_src2;
    end
  end

  // An illegal class would sit in the station forever since no pipe selects it
  a_no_illegal_fu: assert property (@(posedge clk) disable iff (rst)
    (disp_valid && disp_ready) |-> (disp_fu != 2'd3));

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;

`ifdef ISSUE_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk, rst, flush;
  logic       disp_valid, disp_ready, disp_rdy1, disp_rdy2;
  logic [4:0] disp_rob;
  logic [1:0] disp_fu;
  logic [5:0] disp_src1, disp_src2;
  logic       wb0_valid, wb1_valid;
  logic [5:0] wb0_tag, wb1_tag;
  logic       alu_valid, alu_ready, ls_valid, ls_ready, br_valid, br_ready;
  logic [4:0] alu_rob, ls_rob, br_rob;
  logic [5:0] alu_src1, alu_src2, ls_src1, ls_src2, br_src1, br_src2;
  logic [3:0] occupancy;

  rs_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rob(disp_rob),
    .disp_fu(disp_fu), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
    .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb1_valid(wb1_valid), .wb1_tag(wb1_tag),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob(alu_rob),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_rob(ls_rob),
    .ls_src1(ls_src1), .ls_src2(ls_src2),
    .br_valid(br_valid), .br_ready(br_ready), .br_rob(br_rob),
    .br_src1(br_src1), .br_src2(br_src2),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rob;
    logic [5:0] s1;
    logic [5:0] s2;
  } exp_t;

  exp_t q_alu[$];
  exp_t q_ls[$];
  exp_t q_br[$];

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int fu, input int rob, input int s1, input int s2);
    exp_t e;
    e.rob = 5'(rob);
    e.s1  = 6'(s1);
    e.s2  = 6'(s2);
    case (fu)
      0: q_alu.push_back(e);
      1: q_ls.push_back(e);
      default: q_br.push_back(e);
    endcase
    $display("push fu=%0d rob=%0d src1=%0d src2=%0d", fu, rob, s1, s2);
  endtask

  // Monitor: pops the expected micro-op on each accepted issue handshake
  task automatic mon(input int c, input string pfx, input logic v, input logic r,
                     input logic [4:0] rob, input logic [5:0] s1, input logic [5:0] s2);
    int sz;
    exp_t e;
    case (c)
      0: sz = q_alu.size();
      1: sz = q_ls.size();
      default: sz = q_br.size();
    endcase
    if (v && r) begin
      chk({pfx, "_issue_expected"}, (sz > 0) ? 1 : 0, 1);
      if (sz > 0) begin
        case (c)
          0: e = q_alu.pop_front();
          1: e = q_ls.pop_front();
          default: e = q_br.pop_front();
        endcase
        chk({pfx, "_rob"}, rob, e.rob);
        chk({pfx, "_src1"}, s1, e.s1);
        chk({pfx, "_src2"}, s2, e.s2);
        $display("issue %s rob=%0d src1=%0d src2=%0d", pfx, rob, s1, s2);
      end
    end else if (!v) begin
      chk({pfx, "_idle_zero"}, {rob, s1, s2}, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, "alu", alu_valid, alu_ready, alu_rob, alu_src1, alu_src2);
    mon(1, "ls",  ls_valid,  ls_ready,  ls_rob,  ls_src1,  ls_src2);
    mon(2, "br",  br_valid,  br_ready,  br_rob,  br_src1,  br_src2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb0_valid  = 1'b0;
    wb1_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input int rob, input int fu, input int s1, input int s2,
                      input int r1, input int r2);
    disp_valid = 1'b1;
    disp_rob   = 5'(rob);
    disp_fu    = 2'(fu);
    disp_src1  = 6'(s1);
    disp_src2  = 6'(s2);
    disp_rdy1  = (r1 != 0);
    disp_rdy2  = (r2 != 0);
  endtask

  task automatic set_ready(input logic a, input logic l, input logic b);
    alu_ready = a;
    ls_ready  = l;
    br_ready  = b;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    disp_rob = '0; disp_fu = '0; disp_src1 = '0; disp_src2 = '0;
    disp_rdy1 = 1'b0; disp_rdy2 = 1'b0; wb0_tag = '0; wb1_tag = '0;
    set_ready(1'b0, 1'b0, 1'b0);

    // Reset
    nxt();
    smp();
    chk("rst_disp_ready", disp_ready, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_alu_valid", alu_valid, 0);
    nxt();
    rst = 1'b0;
    smp();
    chk("post_rst_disp_ready", disp_ready, 1);

    // 1: ready ALU op is offered one cycle after dispatch
    nxt(); set_ready(1'b1, 1'b1, 1'b1);
    disp(3, 0, 1, 2, 1, 1); push(0, 3, 1, 2);
    smp(); chk("t1_disp_ready", disp_ready, 1); chk("t1_occ0", occupancy, 0);
    chk("t1_same_cycle_valid", alu_valid, 0);
    nxt(); idle();
    smp(); chk("t1_alu_valid", alu_valid, 1); chk("t1_alu_rob", alu_rob, 3);
    chk("t1_occ1", occupancy, 1);
    nxt();
    smp(); chk("t1_occ_after", occupancy, 0); chk("t1_alu_idle", alu_valid, 0);

    // 2: younger ready op bypasses an older waiting one; wakeup latency
    nxt(); disp(1, 0, 4, 9, 1, 0); push(0, 2, 5, 6); push(0, 1, 4, 9);
    smp();
    nxt(); disp(2, 0, 5, 6, 1, 1);
    smp(); chk("t2_wait_valid", alu_valid, 0);
    nxt(); idle();
    smp(); chk("t2_young_valid", alu_valid, 1); chk("t2_young_rob", alu_rob, 2);
    nxt(); wb0_valid = 1'b1; wb0_tag = 6'd9;
    smp(); chk("t2_wake_cycle_valid", alu_valid, BYP ? 1 : 0);
    chk("t2_wake_cycle_rob", alu_rob, BYP ? 1 : 0);
    nxt(); idle();
    smp(); chk("t2_after_wake_valid", alu_valid, BYP ? 0 : 1);
    chk("t2_after_wake_rob", alu_rob, BYP ? 0 : 1);
    nxt();
    smp(); chk("t2_occ_after", occupancy, 0);

    // 3: fill to capacity, full back-pressure, drain in age order
    set_ready(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      nxt(); disp(10 + k, 0, 40 + k, 48 + k, 1, 1); push(0, 10 + k, 40 + k, 48 + k);
      smp(); chk("t3_fill_disp_ready", disp_ready, 1);
    end
    nxt(); disp(20, 0, 1, 1, 1, 1);
    smp(); chk("t3_full_occ", occupancy, 8); chk("t3_full_disp_ready", disp_ready, 0);
    chk("t3_full_alu_valid", alu_valid, 1); chk("t3_full_alu_rob", alu_rob, 10);
    nxt(); alu_ready = 1'b1;
    smp(); chk("t3_issue_cycle_disp_ready", disp_ready, 0);
    nxt(); disp_valid = 1'b0;
    smp(); chk("t3_after_issue_occ", occupancy, 7);
    chk("t3_after_issue_disp_ready", disp_ready, 1);
    repeat (7) nxt();
    smp(); chk("t3_drained_occ", occupancy, 0);

    // 4: one op per class issues in the same cycle
    set_ready(1'b0, 1'b0, 1'b0);
    nxt(); disp(4, 0, 20, 21, 1, 1); push(0, 4, 20, 21); smp();
    nxt(); disp(5, 1, 22, 23, 1, 1); push(1, 5, 22, 23); smp();
    nxt(); disp(6, 2, 24, 25, 1, 1); push(2, 6, 24, 25); smp();
    nxt(); idle(); set_ready(1'b1, 1'b1, 1'b1);
    smp(); chk("t4_alu_valid", alu_valid, 1); chk("t4_ls_valid", ls_valid, 1);
    chk("t4_br_valid", br_valid, 1); chk("t4_occ", occupancy, 3);
    chk("t4_ls_rob", ls_rob, 5); chk("t4_br_rob", br_rob, 6);
    nxt();
    smp(); chk("t4_occ_after", occupancy, 0);

    // 5: operand captured from a wakeup in the dispatch cycle
    nxt(); disp(7, 0, 12, 13, 0, 1); wb1_valid = 1'b1; wb1_tag = 6'd12; push(0, 7, 12, 13);
    smp(); chk("t5_disp_ready", disp_ready, 1);
    nxt(); idle();
    smp(); chk("t5_alu_valid", alu_valid, 1); chk("t5_alu_rob", alu_rob, 7);
    nxt();
    smp(); chk("t5_occ_after", occupancy, 0);

    // 6: flush with five resident entries; dispatch and wakeup dropped
    set_ready(1'b0, 1'b0, 1'b0);
    nxt(); disp(21, 0, 1, 2, 1, 1); smp();
    nxt(); disp(22, 0, 3, 30, 1, 0); smp();
    nxt(); disp(23, 1, 4, 5, 1, 1); smp();
    nxt(); disp(24, 2, 6, 7, 1, 1); smp();
    nxt(); disp(25, 0, 8, 9, 1, 1); smp();
    nxt(); idle();
    smp(); chk("t6_pre_occ", occupancy, 5); chk("t6_pre_alu_valid", alu_valid, 1);
    chk("t6_pre_alu_rob", alu_rob, 21);
    nxt(); flush = 1'b1; set_ready(1'b1, 1'b1, 1'b1);
    wb0_valid = 1'b1; wb0_tag = 6'd30; disp(26, 0, 10, 11, 1, 1);
    smp(); chk("t6_flush_alu_valid", alu_valid, 0); chk("t6_flush_ls_valid", ls_valid, 0);
    chk("t6_flush_br_valid", br_valid, 0); chk("t6_flush_disp_ready", disp_ready, 0);
    nxt(); idle();
    smp(); chk("t6_occ_after", occupancy, 0); chk("t6_alu_after", alu_valid, 0);
    nxt();
    smp(); chk("t6_occ_later", occupancy, 0);

    // 7: reset mid-operation clears entries and outputs
    set_ready(1'b0, 1'b0, 1'b0);
    nxt(); disp(8, 0, 1, 2, 1, 1); smp();
    nxt(); disp(9, 1, 3, 4, 1, 1); smp();
    nxt(); idle(); rst = 1'b1; set_ready(1'b1, 1'b1, 1'b1);
    smp(); chk("t7_rst_alu_valid", alu_valid, 0); chk("t7_rst_ls_valid", ls_valid, 0);
    chk("t7_rst_disp_ready", disp_ready, 0);
    nxt(); rst = 1'b0;
    smp(); chk("t7_occ_after", occupancy, 0); chk("t7_disp_ready_after", disp_ready, 1);

    nxt();
    smp();
    chk("end_alu_queue_empty", q_alu.size(), 0);
    chk("end_ls_queue_empty", q_ls.size(), 0);
    chk("end_br_queue_empty", q_br.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
# rs_issue_scheduler

Unified reservation-station scheduler that sits between dispatch and the ALU, load/store and branch execution pipes. Holds up to RS_DEPTH renamed micro-ops, tracks operand readiness from writeback wakeup broadcasts, and each cycle selects the oldest ready entry per functional-unit class for issue. Flush empties the station in one cycle.

## Interface
- ROB_WIDTH, 5, ROB index width (entry identity)
- PHY_WIDTH, 6, physical register tag width
- RS_DEPTH, 8, entry count (2..32)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous squash of all entries
- disp_valid  in  1  dispatch offers one micro-op
- disp_ready  out  1  station accepts this cycle
- disp_rob  in  ROB_WIDTH  ROB index
- disp_fu  in  2  class: 0 ALU, 1 LS, 2 BR; 3 illegal
- disp_src1, disp_src2  in  PHY_WIDTH  source physical tags
- disp_rdy1, disp_rdy2  in  1  source already available at dispatch
- wb0_valid, wb1_valid  in  1  wakeup broadcast valid
- wb0_tag, wb1_tag  in  PHY_WIDTH  physical tag being written
- alu_valid, ls_valid, br_valid  out  1  selected entry offered to pipe
- alu_ready, ls_ready, br_ready  in  1  pipe accepts
- alu_rob/ls_rob/br_rob  out  ROB_WIDTH  selected ROB index
- alu_src1/alu_src2, ls_src1/ls_src2, br_src1/br_src2  out  PHY_WIDTH  selected source tags
- occupancy  out  $clog2(RS_DEPTH+1)  valid entry count

## Operation
- Entry: valid, rob, fu, src1/src2, rdy1/rdy2, age sequence. Eligible = valid && rdy1 && rdy2.
- Dispatch: accepted when disp_valid && disp_ready; writes any free slot; age = newer than all resident entries. disp_fu==3 accepted and never issued is forbidden; assertion fires.
- disp_ready = (occupancy < RS_DEPTH) && !flush && !rst. Slots freed by issue in the same cycle do not count.
- Dispatch-time capture (always): rdyN set if disp_rdyN or disp_srcN matches a same-cycle valid wakeup tag.
- Wakeup: every valid entry sets rdyN when srcN equals wb0_tag (wb0_valid) or wb1_tag (wb1_valid). Both ports may carry the same tag; ready bits are sticky until the entry frees.
- Select: per class independently, oldest eligible entry; x_valid=1 and outputs show its fields. Outputs are 0 when x_valid=0.
- Issue: on x_valid && x_ready the entry frees at that edge. If not ready, the same entry is held unless an older entry of that class becomes eligible (oldest always wins).
- Up to 3 issues and 1 dispatch per cycle; occupancy' = occupancy + accept − issues.
- flush: x_valid forced 0 that cycle; all entries invalid after the edge; occupancy 0. Dispatch and wakeups in the flush cycle are dropped.

## Timing
- Reset: all entries invalid; occupancy 0; alu/ls/br_valid 0, all rob/src outputs 0; disp_ready 0 during rst, 1 the cycle after.
- Dispatch-to-issue: entry dispatched ready at edge N is offered in cycle N+1 (minimum latency 1).
- Wakeup-to-issue: see Configuration.
- Issue outputs combinational from state (and wakeup when bypass enabled); no registered output stage.
- rst mid-operation behaves as flush plus output clear; rst has priority over flush.

## Configuration
- ISSUE_WAKEUP_BYPASS_EN defined: eligibility also considers same-cycle wakeups; an entry whose last pending operand is broadcast in cycle N can be offered in cycle N (0-cycle wakeup-to-select).
- Not defined: wakeups update ready bits at the edge; earliest offer is cycle N+1. Dispatch-time capture present in both builds.

## Test plan
- Reset then dispatch ALU rob=3, rdy1=rdy2=1, alu_ready=1 -> alu_valid=1, alu_rob=3 next cycle; occupancy returns 0 after issue edge.
- Dispatch ALU rob=1 (src2=9 not ready) then ALU rob=2 ready; wb0 tag=9 -> rob=2 issues first; rob=1 offered cycle after wakeup (same cycle with ISSUE_WAKEUP_BYPASS_EN).
- Fill 8 entries, all ready, alu_ready=0 -> disp_ready=0, occupancy=8; single issue then frees slot; disp_ready=1 next cycle, not same cycle.
- One ready ALU, LS, BR entry each, all pipe readies=1 -> three valids same cycle, occupancy drops by 3.
- Dispatch in same cycle as wb1 tag matching disp_src1 (disp_rdy1=0) -> entry treated ready, issues next cycle.
- Flush with 5 entries and alu_valid=1 -> all valids 0 that cycle, occupancy 0 next; wakeup during flush ignored.
